pico_gpio_irq: RTL and testbench
================================

Name: pico_gpio_irq

Overview:
Parametrised GPIO peripheral that slaves on the picorv32 native memory bus. It generalises the single-LED MMIO write into a register bank: NUM_OUT output pins, NUM_IN synchronised input pins, and per-input edge-detected interrupts with enable and write-1-to-clear pending bits. The irq output feeds one picorv32 irq line, for example irq[3].

Parameters:
BASE_ADDR, 32'h0000_4000, byte address of register 0. Must be 32-byte aligned.
NUM_OUT, 8, number of output pins (1..32).
NUM_IN, 4, number of input pins (1..32).
SYNC_STAGES, 2, input synchroniser flops per pin (>=2).
DEBOUNCE_CYCLES, 16'd50000, debounce window in clk cycles. Used only with GPIO_DEBOUNCE_EN.

Ports:
clk        in   1        system clock
resetn     in   1        asynchronous, active-low reset
mem_valid  in   1        picorv32 bus request
mem_addr   in   32       byte address
mem_wdata  in   32       write data
mem_wstrb  in   4        byte strobes; 0 means read
mem_ready  out  1        transfer complete, one-cycle pulse
mem_rdata  out  32       read data, valid while mem_ready=1
gpio_in    in   NUM_IN   asynchronous input pins
gpio_out   out  NUM_OUT  output register value
irq        out  1        level interrupt, |(PEND & EN)

Behaviour:
- Reset (async, resetn=0): gpio_out=0, mem_ready=0, mem_rdata=0, irq=0. EN, PEND and EDGE are 0. Synchroniser and previous-value flops are 0.
- Address decode: hit = mem_valid && !mem_ready && (mem_addr & ~32'h1F) == BASE_ADDR. Offset = mem_addr[4:2].
- Bus misses: the block never asserts mem_ready and does not drive mem_rdata (drives 0).
- Handshake: on a hit in cycle N, mem_ready=1 in cycle N+1 for exactly one cycle, with mem_rdata valid; it returns to 0 in N+2. Write side effects commit at the clk edge ending cycle N. Back-to-back hits are served every 2 cycles.
- Register map (offset, access):
  0x00 OUT, RW: bits [NUM_OUT-1:0] drive gpio_out.
  0x04 IN, RO: synchronised inputs; writes are ignored.
  0x08 EN, RW: per-input irq enable.
  0x0C PEND, RW1C: writing 1 clears the bit, writing 0 has no effect.
  0x10 EDGE, RW: per-input edge select, 0=rising, 1=falling.
  0x14..0x1C: read 0, writes ignored, still acknowledged.
- Byte strobes: writes honour mem_wstrb per byte on every writable register, including the PEND clear mask.
- Width rules: bits at or above NUM_OUT/NUM_IN read 0 and are not stored.
- Synchroniser: gpio_in passes through SYNC_STAGES flops to give s_in. The IN register reads s_in, so the input-to-IN latency is SYNC_STAGES cycles.
- Edge detection: prev <= s_in every cycle. rise = s_in & ~prev, fall = ~s_in & prev. ev[i] = EDGE[i] ? fall[i] : rise[i].
- Pending: PEND[i] sets on ev[i] regardless of EN[i]. If an event and a W1C clear hit the same bit in the same cycle, set wins.
- irq: combinational from the registered PEND and EN. It asserts the cycle after PEND sets and deasserts the cycle after the clearing write commits, or after EN is cleared.
- Changing EDGE[i] does not generate a spurious event; only s_in transitions create events.
- Reset mid-transfer: a pending mem_ready is dropped immediately, and the core is also reset.

Optional Feature:
GPIO_DEBOUNCE_EN.
- Defined: each input gets a per-pin counter after the synchroniser. The debounced value db[i] updates to s_in[i] only after s_in[i] has differed from db[i] for DEBOUNCE_CYCLES consecutive cycles; the counter resets whenever they match. IN, edge detection and prev all use db instead of s_in. Counters reset to 0 and db resets to 0.
- Undefined: there is no counter logic, and db is s_in.

Test Plan:
- Reset with gpio_in=4'b0000, then read 0x00, 0x04, 0x08, 0x0C -> all mem_rdata=0, mem_ready one pulse each, 1 cycle after mem_valid, irq=0.
- Write 0x000000A5 to 0x4000 with wstrb=4'b1111, then write 0xFF to 0x4000 with wstrb=4'b0010 -> gpio_out=8'hA5 after both writes; readback returns 0x000000A5.
- EN=4'b1000, EDGE=0; drive gpio_in[3] 0->1 -> IN reads 4'b1000 after 2 cycles, PEND=4'b1000, irq=1. Write 0x8 to 0x400C -> PEND=0, irq=0.
- EDGE[0]=1, EN[0]=0; pulse gpio_in[0] 1->0 -> PEND[0]=1, irq=0. Then set EN[0]=1 -> irq=1.
- Issue the W1C clear of PEND[3] in the same cycle a new rising edge on s_in[3] is detected -> PEND[3] stays 1, irq stays 1.
- Access 0x4020 and 0x3FFC -> no mem_ready from the block. Read 0x4018 -> ready with rdata=0. With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4, a 3-cycle glitch produces no PEND, and a 6-cycle level sets PEND.

Source files
------------

// File: rtl/pico_gpio_irq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pico_gpio_irq
// Purpose  : GPIO peripheral on the picorv32 native memory bus. Provides an
//            output register, synchronised inputs and per-input
//            edge-detected interrupts with enable and write-1-to-clear
//            pending bits. irq is a level output for one picorv32 irq line.
// Ports    : clk, resetn (async, active-low)
//            mem_valid/mem_addr/mem_wdata/mem_wstrb -> bus request
//            mem_ready/mem_rdata                    -> one-cycle response
//            gpio_in  [NUM_IN-1:0]  asynchronous input pins
//            gpio_out [NUM_OUT-1:0] output register value
//            irq                    |(PEND & EN)
// Register : 0x00 OUT RW, 0x04 IN RO, 0x08 EN RW, 0x0C PEND RW1C,
//            0x10 EDGE RW (0=rising, 1=falling), 0x14..0x1C read 0
// Options  : define GPIO_DEBOUNCE_EN to insert a per-pin debounce counter
//            (window DEBOUNCE_CYCLES) after the synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module pico_gpio_irq #(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_4000,
   parameter int          NUM_OUT         = 8,
   parameter int          NUM_IN          = 4,
   parameter int          SYNC_STAGES     = 2,
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               mem_valid,
   input  logic [31:0]        mem_addr,
   input  logic [31:0]        mem_wdata,
   input  logic [3:0]         mem_wstrb,
   output logic               mem_ready,
   output logic [31:0]        mem_rdata,
   input  logic [NUM_IN-1:0]  gpio_in,
   output logic [NUM_OUT-1:0] gpio_out,
   output logic               irq
);

   localparam logic [31:0] C_OFS_MASK = 32'h0000_001F;
   localparam logic [2:0]  C_REG_OUT  = 3'd0;
   localparam logic [2:0]  C_REG_IN   = 3'd1;
   localparam logic [2:0]  C_REG_EN   = 3'd2;
   localparam logic [2:0]  C_REG_PEND = 3'd3;
   localparam logic [2:0]  C_REG_EDGE = 3'd4;

   logic                r_ready;
   logic [31:0]         r_rdata;
   logic [NUM_OUT-1:0]  r_out;
   logic [NUM_IN-1:0]   r_en;
   logic [NUM_IN-1:0]   r_pend;
   logic [NUM_IN-1:0]   r_edge;
   logic [NUM_IN-1:0]   r_prev;
   logic [SYNC_STAGES-1:0][NUM_IN-1:0] r_sync;

   logic                w_hit;
   logic                w_we;
   logic [2:0]          w_off;
   logic [31:0]         w_bmask;
   logic [31:0]         w_rd;
   logic [31:0]         w_out_nxt;
   logic [31:0]         w_en_nxt;
   logic [31:0]         w_edge_nxt;
   logic [31:0]         w_clr;
   logic [NUM_IN-1:0]   w_s_in;
   logic [NUM_IN-1:0]   w_db;
   logic [NUM_IN-1:0]   w_ev;
   logic                w_unused;

   // The !r_ready term blocks a held request from being served twice.
   assign w_hit   = mem_valid && !r_ready && ((mem_addr & ~C_OFS_MASK) == BASE_ADDR);
   assign w_we    = w_hit && (mem_wstrb != 4'b0000);
   assign w_off   = mem_addr[4:2];
   assign w_bmask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                     {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};

   // Byte-merged next values; only the low implemented bits are stored.
   assign w_out_nxt  = (32'(r_out)  & ~w_bmask) | (mem_wdata & w_bmask);
   assign w_en_nxt   = (32'(r_en)   & ~w_bmask) | (mem_wdata & w_bmask);
   assign w_edge_nxt = (32'(r_edge) & ~w_bmask) | (mem_wdata & w_bmask);
   assign w_clr      = (w_we && (w_off == C_REG_PEND)) ? (mem_wdata & w_bmask) : 32'h0;

   always_comb begin
      w_rd = 32'h0;
      case (w_off)
         C_REG_OUT:  w_rd = 32'(r_out);
         C_REG_IN:   w_rd = 32'(w_db);
         C_REG_EN:   w_rd = 32'(r_en);
         C_REG_PEND: w_rd = 32'(r_pend);
         C_REG_EDGE: w_rd = 32'(r_edge);
         default:    w_rd = 32'h0;
      endcase
   end

   // Input synchroniser: oldest stage is the clean sample.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_sync <= '0;
      else         r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
   end
   assign w_s_in = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   // db follows s_in only after DEBOUNCE_CYCLES consecutive differing cycles.
   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_db
      logic [15:0] r_cnt;
      logic        r_db_bit;
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            r_cnt    <= 16'd0;
            r_db_bit <= 1'b0;
         end else if (w_s_in[gi] == r_db_bit) begin
            r_cnt <= 16'd0;
         end else if (r_cnt >= DEBOUNCE_CYCLES - 16'd1) begin
            r_db_bit <= w_s_in[gi];
            r_cnt    <= 16'd0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
      assign w_db[gi] = r_db_bit;
   end
`else
   assign w_db = w_s_in;
`endif

   // Events come only from input transitions, so rewriting EDGE alone
   // never creates one.
   assign w_ev = (r_edge & ~w_db & r_prev) | (~r_edge & w_db & ~r_prev);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ready <= 1'b0;
         r_rdata <= 32'h0;
         r_out   <= '0;
         r_en    <= '0;
         r_pend  <= '0;
         r_edge  <= '0;
         r_prev  <= '0;
      end else begin
         r_ready <= w_hit;
         r_rdata <= w_hit ? w_rd : 32'h0;
         r_prev  <= w_db;
         if (w_we && (w_off == C_REG_OUT))  r_out  <= w_out_nxt[NUM_OUT-1:0];
         if (w_we && (w_off == C_REG_EN))   r_en   <= w_en_nxt[NUM_IN-1:0];
         if (w_we && (w_off == C_REG_EDGE)) r_edge <= w_edge_nxt[NUM_IN-1:0];
         // OR-ing events after the clear makes a same-cycle event win.
         r_pend <= (r_pend & ~w_clr[NUM_IN-1:0]) | w_ev;
      end
   end

   assign mem_ready = r_ready;
   assign mem_rdata = r_rdata;
   assign gpio_out  = r_out;
   assign irq       = |(r_pend & r_en);

   assign w_unused = ^{w_out_nxt, w_en_nxt, w_edge_nxt, w_clr, DEBOUNCE_CYCLES};

endmodule
`default_nettype wire

// File: tb/tb_pico_gpio_irq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pico_gpio_irq
// Purpose  : Self-checking bench for pico_gpio_irq. A behavioural register
//            model is advanced at every rising edge and compared with the
//            DUT outputs at every falling edge; directed bus sequences add
//            literal expectations, followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pico_gpio_irq;

   localparam logic [31:0] BASE = 32'h0000_4000;
   localparam int NO  = 8;
   localparam int NI  = 4;
   localparam int SS  = 2;
   localparam int DEB = 4;
`ifdef GPIO_DEBOUNCE_EN
   localparam int DLY = SS + DEB;
`else
   localparam int DLY = SS;
`endif

   logic          clk = 1'b0;
   logic          resetn;
   logic          mem_valid;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wstrb;
   logic          mem_ready;
   logic [31:0]   mem_rdata;
   logic [NI-1:0] gpio_in;
   logic [NO-1:0] gpio_out;
   logic          irq;

   always #5 clk = ~clk;

   pico_gpio_irq #(
      .BASE_ADDR(BASE), .NUM_OUT(NO), .NUM_IN(NI),
      .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(16'(DEB))
   ) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [NO-1:0] m_out;
   logic [NI-1:0] m_en, m_pend, m_edge, m_prev, m_db, m_sin;
   logic          m_ready;
   logic [31:0]   m_rdata;
   logic [NI-1:0] q_in[$];   // recent raw input samples
   logic [NI-1:0] q_s[$];    // recent synchronised samples

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out = '0; m_en = '0; m_pend = '0; m_edge = '0;
      m_prev = '0; m_db = '0; m_sin = '0;
      m_ready = 1'b0; m_rdata = 32'h0;
      q_in.delete();
      q_s.delete();
   endtask

   function automatic logic [31:0] m_read(input logic [2:0] off);
      case (off)
         3'd0:    return 32'(m_out);
         3'd1:    return 32'(m_db);
         3'd2:    return 32'(m_en);
         3'd3:    return 32'(m_pend);
         3'd4:    return 32'(m_edge);
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs present at it.
   task automatic model_step();
      logic          hit, wr;
      logic [2:0]    off;
      logic [31:0]   rd;
      logic [NO-1:0] n_out;
      logic [NI-1:0] n_en, n_edge, clr, ev, n_pend, n_db;
      bit            all_diff;
      if (!resetn) begin
         model_reset();
         return;
      end
      hit = mem_valid && !m_ready && (mem_addr[31:5] == BASE[31:5]);
      off = mem_addr[4:2];
      rd  = m_read(off);
      wr  = hit && (mem_wstrb != 4'b0000);
      n_out = m_out; n_en = m_en; n_edge = m_edge; clr = '0;
      if (wr) begin
         for (int i = 0; i < NO; i++)
            if (off == 3'd0 && mem_wstrb[i/8]) n_out[i] = mem_wdata[i];
         for (int i = 0; i < NI; i++) begin
            if (off == 3'd2 && mem_wstrb[i/8]) n_en[i]   = mem_wdata[i];
            if (off == 3'd3 && mem_wstrb[i/8]) clr[i]    = mem_wdata[i];
            if (off == 3'd4 && mem_wstrb[i/8]) n_edge[i] = mem_wdata[i];
         end
      end
      for (int i = 0; i < NI; i++)
         ev[i] = m_edge[i] ? (m_prev[i] && !m_db[i]) : (!m_prev[i] && m_db[i]);
      n_pend = (m_pend & ~clr) | ev;

      q_in.push_back(gpio_in);
      if (q_in.size() > SS) void'(q_in.pop_front());
`ifdef GPIO_DEBOUNCE_EN
      // Flip a pin once its last DEB synchronised samples all disagree with it.
      q_s.push_back(m_sin);
      if (q_s.size() > DEB) void'(q_s.pop_front());
      n_db = m_db;
      if (q_s.size() == DEB) begin
         for (int i = 0; i < NI; i++) begin
            all_diff = 1'b1;
            foreach (q_s[k]) if (q_s[k][i] == m_db[i]) all_diff = 1'b0;
            if (all_diff) n_db[i] = ~m_db[i];
         end
      end
`endif
      m_sin = (q_in.size() == SS) ? q_in[0] : '0;
`ifndef GPIO_DEBOUNCE_EN
      n_db = m_sin;
`endif
      m_prev  = m_db;
      m_db    = n_db;
      m_out   = n_out;
      m_en    = n_en;
      m_edge  = n_edge;
      m_pend  = n_pend;
      m_ready = hit;
      m_rdata = hit ? rd : 32'h0;
   endtask

   // One clock: model follows the rising edge, DUT compared at falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("gpio_out",  32'(gpio_out), 32'(m_out));
      chk("irq",       32'(irq),      32'(|(m_pend & m_en)));
      chk("mem_ready", 32'(mem_ready), 32'(m_ready));
      chk("mem_rdata", mem_rdata,     m_rdata);
   endtask

   task automatic bus(input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd);
      int lat;
      mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!mem_ready && lat < 8);
      chk("bus_latency", lat, 1);
      rd = mem_rdata;
      mem_valid = 1'b0; mem_wstrb = 4'b0000;
      tick();
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
      logic [31:0] rd;
      bus(addr, wd, ws, rd);
   endtask

   task automatic rdchk(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      bus(addr, 32'h0, 4'b0000, rd);
      chk(name, rd, exp);
   endtask

   task automatic miss(input string name, input logic [31:0] addr, input logic [3:0] ws);
      int seen;
      seen = 0;
      mem_valid = 1'b1; mem_addr = addr; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = ws;
      repeat (4) begin
         tick();
         if (mem_ready) seen++;
      end
      mem_valid = 1'b0; mem_wstrb = 4'b0000;
      tick();
      chk(name, seen, 0);
   endtask

   initial begin
      resetn = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
      mem_wstrb = 4'b0000; gpio_in = '0;
      model_reset();
      repeat (3) tick();
      resetn = 1'b1;
      tick();

      // Reset values
      chk("rst_irq", 32'(irq), 0);
      rdchk("rst_out",  BASE + 32'h00, 32'h0);
      rdchk("rst_in",   BASE + 32'h04, 32'h0);
      rdchk("rst_en",   BASE + 32'h08, 32'h0);
      rdchk("rst_pend", BASE + 32'h0C, 32'h0);

      // Output register with byte strobes
      wr(BASE, 32'h0000_00A5, 4'b1111);
      wr(BASE, 32'h0000_00FF, 4'b0010);
      chk("gpio_out_a5", 32'(gpio_out), 32'h0000_00A5);
      rdchk("out_readback", BASE, 32'h0000_00A5);

      // Rising edge on pin 3 with irq enabled, then W1C
      wr(BASE + 32'h08, 32'h8, 4'b1111);
      wr(BASE + 32'h10, 32'h0, 4'b1111);
      gpio_in = 4'b1000;
      repeat (DLY) tick();
      rdchk("in_sync", BASE + 32'h04, 32'h8);
      chk("irq_rise", 32'(irq), 1);
      rdchk("pend_rise", BASE + 32'h0C, 32'h8);
      wr(BASE + 32'h0C, 32'h8, 4'b1111);
      chk("irq_cleared", 32'(irq), 0);
      rdchk("pend_cleared", BASE + 32'h0C, 32'h0);

      // Falling-edge select on pin 0, masked then enabled
      wr(BASE + 32'h10, 32'h1, 4'b1111);
      gpio_in = 4'b1001;
      repeat (DLY + 4) tick();
      rdchk("pend_rise_on_fall_sel", BASE + 32'h0C, 32'h0);
      gpio_in = 4'b1000;
      repeat (DLY + 4) tick();
      rdchk("pend_fall", BASE + 32'h0C, 32'h1);
      chk("irq_masked", 32'(irq), 0);
      wr(BASE + 32'h08, 32'h9, 4'b1111);
      chk("irq_enabled", 32'(irq), 1);
      wr(BASE + 32'h0C, 32'h1, 4'b1111);
      chk("irq_clr0", 32'(irq), 0);

      // Rewriting EDGE while inputs are stable creates no event
      wr(BASE + 32'h10, 32'hF, 4'b1111);
      repeat (3) tick();
      rdchk("edge_change_no_event", BASE + 32'h0C, 32'h0);
      wr(BASE + 32'h10, 32'h1, 4'b1111);

      // Clear and new event on pin 3 in the same cycle: set wins
      gpio_in = 4'b0000;
      repeat (DLY + 4) tick();
      gpio_in = 4'b1000;
      repeat (DLY + 4) tick();
      rdchk("pend_pre", BASE + 32'h0C, 32'h8);
      gpio_in = 4'b0000;
      repeat (DLY + 4) tick();
      gpio_in = 4'b1000;
      repeat (DLY) tick();
      wr(BASE + 32'h0C, 32'h8, 4'b1111);
      chk("irq_set_wins", 32'(irq), 1);
      rdchk("pend_set_wins", BASE + 32'h0C, 32'h8);

      // Address decode and reserved offsets
      miss("miss_4020", BASE + 32'h20, 4'b1111);
      miss("miss_3ffc", BASE - 32'h4, 4'b1111);
      rdchk("out_after_miss", BASE, 32'h0000_00A5);
      rdchk("rd_reserved_18", BASE + 32'h18, 32'h0);
      wr(BASE + 32'h1C, 32'hFFFF_FFFF, 4'b1111);
      rdchk("rd_reserved_1c", BASE + 32'h1C, 32'h0);
      wr(BASE + 32'h04, 32'h0, 4'b1111);
      rdchk("in_read_only", BASE + 32'h04, 32'h8);
      wr(BASE + 32'h08, 32'hFFFF_FFFF, 4'b1111);
      rdchk("en_width", BASE + 32'h08, 32'hF);

      // Reset while mem_ready is high
      gpio_in = 4'b0000;
      mem_valid = 1'b1; mem_addr = BASE; mem_wstrb = 4'b0000;
      tick();
      chk("ready_before_rst", 32'(mem_ready), 1);
      resetn = 1'b0;
      #1;
      chk("ready_async_drop", 32'(mem_ready), 0);
      chk("out_async_rst", 32'(gpio_out), 0);
      chk("irq_async_rst", 32'(irq), 0);
      mem_valid = 1'b0;
      tick();
      resetn = 1'b1;
      tick();

`ifdef GPIO_DEBOUNCE_EN
      // Short glitch is filtered, a longer level passes
      gpio_in = 4'b0010;
      repeat (3) tick();
      gpio_in = 4'b0000;
      repeat (12) tick();
      rdchk("glitch_filtered", BASE + 32'h0C, 32'h0);
      gpio_in = 4'b0010;
      repeat (6) tick();
      gpio_in = 4'b0000;
      repeat (12) tick();
      rdchk("level_passes", BASE + 32'h0C, 32'h2);
`endif

      // Randomized traffic and input activity
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] r;
         for (int i = 0; i < NI; i++)
            if ($urandom_range(0, 7) == 0) gpio_in[i] = ~gpio_in[i];
         r = 4'($urandom_range(0, 9));
         mem_valid = ($urandom_range(0, 1) == 1);
         if (r < 4'd8)       mem_addr = BASE + 32'(r) * 32'd4;
         else if (r == 4'd8) mem_addr = BASE + 32'h20 + 32'(r) * 32'd4;
         else                mem_addr = BASE - 32'h4;
         mem_addr[1:0] = 2'($urandom);
         mem_wdata = $urandom;
         mem_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
         resetn = (c % 1000 != 999);
         tick();
      end
      resetn = 1'b1;
      mem_valid = 1'b0;
      mem_wstrb = 4'b0000;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
